regfile_wb_ctrl: RTL
====================

# regfile_wb_ctrl

Write-back controller that owns the single write port of the 32×32 general register file. Holds the MEM/WB pipeline register and a 2-entry queue for results from the long-latency multiply/divide unit (MDU), and arbitrates both onto the write port, one write per cycle. Keeps a per-register busy scoreboard so decode can stall on pending MDU destinations. Sits between the MEM stage/MDU and the register file.

## Interface
- DATA_W, 32, register data width
- ADDR_W, 5, register address width
- QDEPTH, 2, MDU result queue depth
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset; synchronous, active-low
- stall_i  in  1  hold MEM/WB register
- flush_i  in  1  invalidate MEM/WB capture
- mem_wreg_i  in  1  MEM stage result writes a register
- mem_wd_i  in  ADDR_W  MEM destination register
- mem_wdata_i  in  DATA_W  MEM result
- mdu_valid_i  in  1  MDU result offered
- mdu_wd_i  in  ADDR_W  MDU destination
- mdu_wdata_i  in  DATA_W  MDU result
- mdu_ready_o  out  1  queue can accept
- issue_en_i  in  1  MDU op issued this cycle
- issue_wd_i  in  ADDR_W  destination of issued MDU op
- wr_en_o  out  1  register file write enable
- wraddr_o  out  ADDR_W  write address
- wrdata_o  out  DATA_W  write data
- busy_o  out  32  scoreboard, bit n = register n has a pending MDU write

## Operation
- MEM/WB register (wb_valid, wb_wd, wb_wdata, wb_done): when stall_i=0, capture valid = mem_wreg_i & ~flush_i & (mem_wd_i≠0), clear wb_done. stall_i=1 holds contents. flush_i with stall_i=1: hold (stall wins).
- Write-port arbitration (combinational from state, no extra latency): pipeline entry if wb_valid & ~wb_done; else queue head if queue non-empty; else idle (wr_en_o=0, wraddr_o=0, wrdata_o=0).
- Pipeline entry written sets wb_done at the edge, so a stalled entry is written exactly once and frees the port for the queue.
- Queue: FIFO, mdu_ready_o = rst & (count<QDEPTH). Push on mdu_valid_i & mdu_ready_o; mdu_wd_i=0 is accepted and discarded (no entry). Pop when head granted the port. Push and pop in the same cycle leave count unchanged; push while full is impossible by handshake. mdu_wdata_i and mdu_wd_i ignored when not valid.
- Scoreboard: issue_en_i & issue_wd_i≠0 sets busy[issue_wd_i]; popping a queue entry clears busy[its wd]. Set and clear of the same bit in one cycle: set wins. busy_o[0] always 0. flush_i and stall_i do not touch the scoreboard.
- Register 0 is never written.

## Timing
- Reset (rst=0 at edge): wb_valid=0, wb_done=0, queue empty, busy_o=0; wr_en_o=0, wraddr_o=0, wrdata_o=0; mdu_ready_o=0 while rst=0. Reset mid-queue drops all pending entries.
- MEM result captured at edge N appears on write port during cycle N→N+1, lands in register file at edge N+1.
- MDU result accepted at edge N is eligible from cycle N→N+1; written at edge N+1 if no pipeline write, else deferred one cycle per pipeline write. busy bit clears at the same edge the write lands.
- Worst case queue wait under continuous pipeline writes is unbounded; mdu_ready_o back-pressure is the only flow control.

## Structure
- Shared package/defines: RegBus, RegAddrBus, RegNum, RegNumLog2, ZeroWord, RstEnable/RstDisable, WriteEnable.
- Sub-module: wb_fifo (parameterised QDEPTH×(ADDR_W+DATA_W) FIFO with push/pop/count/full/empty).

## Test plan
- Reset: hold rst=0 two cycles with mdu_valid_i=1 -> all outputs 0, nothing queued; release -> mdu_ready_o=1.
- Pipeline write: mem_wreg_i=1, wd=5, data=0xDEADBEEF at edge N -> wr_en_o=1, wraddr_o=5, wrdata_o=0xDEADBEEF during N→N+1 only; wd=0 -> no write.
- Stall: capture wd=3, then stall_i=1 for 4 cycles -> exactly one write of reg 3; queued MDU result (wd=7, 0x12345678) written in the second stalled cycle.
- Contention: issue wd=9 (busy_o[9]=1), MDU result wd=9 arrives while pipeline writes every cycle for 3 cycles -> reg 9 written on 4th cycle, busy_o[9] clears at that edge.
- Queue full: two MDU results with continuous pipeline writes -> mdu_ready_o=0; one pop with simultaneous push keeps count=2, FIFO order preserved.
- Scoreboard collision: pop of wd=4 and issue_en_i with wd=4 same cycle -> busy_o[4] remains 1.

Source files
------------

// File: rtl/regfile_wb_ctrl_pkg.sv
// Shared register-file constants and helpers for the write-back controller.
package regfile_wb_ctrl_pkg;

    localparam int RegNum     = 32;
    localparam int RegNumLog2 = 5;

    typedef logic [31:0]           RegBus;
    typedef logic [RegNumLog2-1:0] RegAddrBus;

    localparam RegBus ZeroWord    = 32'h0000_0000;
    localparam logic  RstEnable   = 1'b0;
    localparam logic  RstDisable  = 1'b1;
    localparam logic  WriteEnable = 1'b1;

    // One-hot scoreboard mask for a register; register 0 never gets a bit.
    function automatic logic [RegNum-1:0] reg_mask(input RegAddrBus a);
        reg_mask    = '0;
        reg_mask[a] = (a != '0);
    endfunction

endpackage

// File: rtl/regfile_wb_ctrl_if.sv
// Pipeline, MDU, issue and register-file write port signals of the WB controller.
interface regfile_wb_ctrl_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              stall_i;
    logic              flush_i;
    logic              mem_wreg_i;
    logic [ADDR_W-1:0] mem_wd_i;
    logic [DATA_W-1:0] mem_wdata_i;
    logic              mdu_valid_i;
    logic [ADDR_W-1:0] mdu_wd_i;
    logic [DATA_W-1:0] mdu_wdata_i;
    logic              mdu_ready_o;
    logic              issue_en_i;
    logic [ADDR_W-1:0] issue_wd_i;
    logic              wr_en_o;
    logic [ADDR_W-1:0] wraddr_o;
    logic [DATA_W-1:0] wrdata_o;
    logic [31:0]       busy_o;

    // Controller side.
    modport slave (
        input  stall_i, flush_i, mem_wreg_i, mem_wd_i, mem_wdata_i,
        input  mdu_valid_i, mdu_wd_i, mdu_wdata_i, issue_en_i, issue_wd_i,
        output mdu_ready_o, wr_en_o, wraddr_o, wrdata_o, busy_o
    );

    // Pipeline / environment side.
    modport master (
        output stall_i, flush_i, mem_wreg_i, mem_wd_i, mem_wdata_i,
        output mdu_valid_i, mdu_wd_i, mdu_wdata_i, issue_en_i, issue_wd_i,
        input  mdu_ready_o, wr_en_o, wraddr_o, wrdata_o, busy_o
    );
endinterface

// File: rtl/regfile_wb_ctrl_fifo.sv
// Small FIFO holding MDU results (destination + data) waiting for the write port.
module wb_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 37,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  dout,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);
    import regfile_wb_ctrl_pkg::*;

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
    localparam logic [CW-1:0] CMAX = CW'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] cnt;

    // Storage: no reset needed, entries are only read when counted valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

    // Pointers and occupancy; reset discards everything pending.
    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
            if (pop)  rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    assign dout  = mem[rd_ptr];
    assign count = cnt;
    assign full  = (cnt == CMAX);
    assign empty = (cnt == '0);

endmodule

// File: rtl/regfile_wb_ctrl.sv
// Write-back controller: MEM/WB register, MDU result queue, write-port
// arbitration and the pending-MDU-write scoreboard.
module regfile_wb_ctrl
    import regfile_wb_ctrl_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int QDEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    regfile_wb_ctrl_if.slave  bus
);
    localparam int CW = $clog2(QDEPTH + 1);
    localparam logic [CW-1:0] QFULL = CW'(QDEPTH);

    logic              wb_valid, wb_done;
    logic [ADDR_W-1:0] wb_wd;
    logic [DATA_W-1:0] wb_wdata;

    logic              grant_pipe, grant_q;
    logic              q_push, q_full, q_empty;
    logic [CW-1:0]     q_count;
    logic [ADDR_W+DATA_W-1:0] q_dout;
    logic [ADDR_W-1:0] q_wd;
    logic [DATA_W-1:0] q_wdata;

    logic [RegNum-1:0] busy, busy_nxt;

    // MEM/WB register: stall holds (and beats flush); a written entry is marked
    // done so a long stall writes it once and hands the port to the queue.
    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            wb_valid <= 1'b0;
            wb_done  <= 1'b0;
            wb_wd    <= '0;
            wb_wdata <= '0;
        end else if (!bus.stall_i) begin
            wb_valid <= bus.mem_wreg_i & ~bus.flush_i & (bus.mem_wd_i != '0);
            wb_done  <= 1'b0;
            wb_wd    <= bus.mem_wd_i;
            wb_wdata <= bus.mem_wdata_i;
        end else if (grant_pipe) begin
            wb_done  <= 1'b1;
        end
    end

    // Destination 0 results are dropped at the door rather than queued.
    assign q_push = bus.mdu_valid_i & (rst == RstDisable) & ~q_full
                  & (bus.mdu_wd_i != '0);

    wb_fifo #(
        .DEPTH (QDEPTH),
        .W     (ADDR_W + DATA_W),
        .CW    (CW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (q_push),
        .pop   (grant_q),
        .din   ({bus.mdu_wd_i, bus.mdu_wdata_i}),
        .dout  (q_dout),
        .count (q_count),
        .full  (q_full),
        .empty (q_empty)
    );

    assign {q_wd, q_wdata} = q_dout;

    // Pipeline results have priority; the queue head fills any idle slot.
    assign grant_pipe = wb_valid & ~wb_done;
    assign grant_q    = ~grant_pipe & ~q_empty;

    // Write port mux, zeroed when idle.
    always_comb begin
        bus.wr_en_o  = 1'b0;
        bus.wraddr_o = '0;
        bus.wrdata_o = '0;
        if (grant_pipe) begin
            bus.wr_en_o  = WriteEnable;
            bus.wraddr_o = wb_wd;
            bus.wrdata_o = wb_wdata;
        end else if (grant_q) begin
            bus.wr_en_o  = WriteEnable;
            bus.wraddr_o = q_wd;
            bus.wrdata_o = q_wdata;
        end
    end

    // Scoreboard next state: clear on pop, then set on issue so set wins.
    always_comb begin
        busy_nxt = busy;
        if (grant_q)
            busy_nxt = busy_nxt & ~reg_mask(RegAddrBus'(q_wd));
        if (bus.issue_en_i)
            busy_nxt = busy_nxt | reg_mask(RegAddrBus'(bus.issue_wd_i));
        busy_nxt[0] = 1'b0;
    end

    // Scoreboard register.
    always_ff @(posedge clk) begin
        if (rst == RstEnable) busy <= '0;
        else                  busy <= busy_nxt;
    end

    assign bus.busy_o      = busy;
    assign bus.mdu_ready_o = (rst == RstDisable) & (q_count < QFULL);

endmodule
